// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_DW       = 8;
    localparam int DEF_MAXBURST = 4;

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// Combinational round-robin search: first set req bit at or above prio_ptr,
// wrapping to the lowest set bit when nothing at or above the pointer requests.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int N  = DEF_N,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] prio_ptr,
    output logic          valid,
    output logic [IW-1:0] winner
);

    logic          w_hi_found;
    logic          w_lo_found;
    logic [IW-1:0] w_hi_idx;
    logic [IW-1:0] w_lo_idx;

    // Descending scan so the final assignment holds the lowest matching index.
    always_comb begin
        w_hi_found = 1'b0;
        w_lo_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                w_lo_found = 1'b1;
                w_lo_idx   = IW'(i);
                if (IW'(i) >= prio_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_idx   = IW'(i);
                end
            end
        end
    end

    always_comb begin
        valid  = w_lo_found;
        winner = w_hi_found ? w_hi_idx : w_lo_idx;
    end

endmodule

// File: rtl/fifo_wr_arb.sv
// Burst-locking round-robin arbiter feeding one downstream FIFO write port.
// One bubble cycle per arbitration; a locked owner streams up to MAXBURST beats.
//
// state | meaning
// IDLE  | no owner locked; arbitrate among req, outputs quiet
// BURST | owner locked; accept req[owner] beats while FIFO not full
module fifo_wr_arb import fifo_arb_pkg::*; #(
    parameter int N        = DEF_N,
    parameter int DW       = DEF_DW,
    parameter int MAXBURST = DEF_MAXBURST,
    parameter int IW       = $clog2(N),
    parameter int CW       = $clog2(MAXBURST + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N-1:0]    req,
    input  logic [N*DW-1:0] data,
    input  logic [N-1:0]    last,
    output logic [N-1:0]    gnt,
    output logic            fifo_we,
    output logic [DW-1:0]   fifo_wd,
    input  logic            fifo_full,
    output logic            busy,
    output logic [IW-1:0]   owner,
    output logic [CW-1:0]   beat_cnt
);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic [IW-1:0] r_owner;
    logic [IW-1:0] w_owner_nxt;
    logic [IW-1:0] r_prio_ptr;
    logic [IW-1:0] w_ptr_nxt;
    logic [IW-1:0] w_ptr_after;
    logic [CW-1:0] r_beat_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [CW-1:0] w_cnt_inc;

    logic          w_pick_valid;
    logic [IW-1:0] w_pick_idx;
    logic          w_own_req;
    logic          w_own_last;
    logic [DW-1:0] w_own_data;
    logic          w_accept;
    logic          w_busy;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_rr_pick (
        .req      (req),
        .prio_ptr (r_prio_ptr),
        .valid    (w_pick_valid),
        .winner   (w_pick_idx)
    );

    // Owner-side view of the requester bus.
    always_comb begin
        w_own_req  = 1'b0;
        w_own_last = 1'b0;
        w_own_data = '0;
        for (int i = 0; i < N; i++) begin
            if (r_owner == IW'(i)) begin
                w_own_req  = req[i];
                w_own_last = last[i];
                w_own_data = data[i*DW +: DW];
            end
        end
    end

    assign w_cnt_inc   = r_beat_cnt + CW'(1);
    assign w_ptr_after = (r_owner == IW'(N - 1)) ? '0 : r_owner + IW'(1);

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_beat_cnt;
        w_ptr_nxt   = r_prio_ptr;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pick_valid) begin
                    w_owner_nxt = w_pick_idx;
                    w_cnt_nxt   = '0;
                    w_state_nxt = BURST;
                end
            end
            BURST: begin
                if (!w_own_req) begin
                    w_state_nxt = IDLE;
                    w_ptr_nxt   = w_ptr_after;
                end else if (!fifo_full) begin
                    w_accept  = 1'b1;
                    w_cnt_nxt = w_cnt_inc;
                    if (w_own_last || (w_cnt_inc == CW'(MAXBURST))) begin
                        w_state_nxt = IDLE;
                        w_ptr_nxt   = w_ptr_after;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= '0;
            r_prio_ptr <= '0;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_owner    <= w_owner_nxt;
            r_prio_ptr <= w_ptr_nxt;
            r_beat_cnt <= w_cnt_nxt;
        end
    end

    // Outputs gated by reset so a mid-burst reset cannot leak a partial write.
    assign w_busy = (r_state == BURST) && !reset;

    always_comb begin
        gnt = '0;
        for (int i = 0; i < N; i++) begin
            gnt[i] = w_accept && w_busy && (r_owner == IW'(i));
        end
    end

    assign fifo_we  = w_accept && w_busy;
    assign fifo_wd  = w_busy ? w_own_data : '0;
    assign busy     = w_busy;
    assign owner    = r_owner;
    assign beat_cnt = r_beat_cnt;

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Scoreboard bench for fifo_wr_arb: a burst-level reference model queues
// expected per-cycle status and expected FIFO writes; a monitor checks them.
`timescale 1ns/1ps
module tb_fifo_wr_arb;

    localparam int N        = 4;
    localparam int DW       = 8;
    localparam int MAXBURST = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    req = '0;
    logic [31:0]   data = '0;
    logic [3:0]    last = '0;
    logic          fifo_full = 1'b0;
    logic [3:0]    gnt;
    logic          fifo_we;
    logic [7:0]    fifo_wd;
    logic          busy;
    logic [1:0]    owner;
    logic [2:0]    beat_cnt;

    fifo_wr_arb #(.N(N), .DW(DW), .MAXBURST(MAXBURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
        .last      (last),
        .gnt       (gnt),
        .fifo_we   (fifo_we),
        .fifo_wd   (fifo_wd),
        .fifo_full (fifo_full),
        .busy      (busy),
        .owner     (owner),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int busy;
        int owner;
        int cnt;
        int we;
        int gnt;
        int wd;
    } stat_t;

    typedef struct {
        int wd;
        int gnt;
    } wr_t;

    stat_t sq[$];
    wr_t   wq[$];
    int    wr_owner[$];

    int n_vec = 0;
    int n_err = 0;
    int n_we  = 0;

    // Reference model: a locked requester (or none), beats taken, round-robin pointer.
    bit m_locked = 0;
    int m_owner  = 0;
    int m_beats  = 0;
    int m_ptr    = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model(input logic [3:0] rq, input logic [31:0] dt,
                         input logic [3:0] ls, input logic fl, input logic rs);
        stat_t s;
        wr_t   w;
        bit    take;
        if (rs) begin
            s = '{0, 0, 0, 0, 0, 0};
            sq.push_back(s);
            m_locked = 0; m_owner = 0; m_beats = 0; m_ptr = 0;
            return;
        end
        take    = m_locked && rq[m_owner] && !fl;
        s.busy  = m_locked ? 1 : 0;
        s.owner = m_owner;
        s.cnt   = m_beats;
        s.we    = take ? 1 : 0;
        s.gnt   = take ? (1 << m_owner) : 0;
        s.wd    = m_locked ? int'(dt[m_owner*8 +: 8]) : 0;
        sq.push_back(s);
        if (take) begin
            w.wd  = int'(dt[m_owner*8 +: 8]);
            w.gnt = 1 << m_owner;
            wq.push_back(w);
        end
        if (!m_locked) begin
            for (int k = 0; k < N; k++) begin
                if (!m_locked && rq[(m_ptr + k) % N]) begin
                    m_locked = 1;
                    m_owner  = (m_ptr + k) % N;
                    m_beats  = 0;
                end
            end
        end else if (!rq[m_owner]) begin
            m_locked = 0;
            m_ptr    = (m_owner + 1) % N;
        end else if (take) begin
            m_beats++;
            if (ls[m_owner] || m_beats == MAXBURST) begin
                m_locked = 0;
                m_ptr    = (m_owner + 1) % N;
            end
        end
    endtask

    task automatic cyc(input logic [3:0] rq, input logic [31:0] dt,
                       input logic [3:0] ls, input logic fl, input logic rs);
        @(posedge clk);
        #1;
        req = rq; data = dt; last = ls; fifo_full = fl; reset = rs;
        model(rq, dt, ls, fl, rs);
    endtask

    function automatic logic [31:0] lane(input int idx, input logic [7:0] b);
        logic [31:0] v;
        v = $urandom;
        v[idx*8 +: 8] = b;
        return v;
    endfunction

    task automatic probe();
        @(negedge clk);
        #1;
    endtask

    // Monitor: per-cycle status every negedge, write payload whenever fifo_we is seen.
    initial begin
        stat_t s;
        wr_t   w;
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("busy",     int'(busy),     s.busy);
                chk("owner",    int'(owner),    s.owner);
                chk("beat_cnt", int'(beat_cnt), s.cnt);
                chk("fifo_we",  int'(fifo_we),  s.we);
                chk("gnt",      int'(gnt),      s.gnt);
                chk("fifo_wd",  int'(fifo_wd),  s.wd);
            end
            if (fifo_we) begin
                n_we++;
                for (int i = 0; i < N; i++) if (gnt[i]) wr_owner.push_back(i);
                if (wq.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wr_unexpected: got write 0x%02h expected none at %0t", fifo_wd, $time);
                end else begin
                    w = wq.pop_front();
                    chk("wr_data", int'(fifo_wd), w.wd);
                    chk("wr_gnt",  int'(gnt),     w.gnt);
                end
            end
        end
    end

    initial begin
        int          snap;
        logic [3:0]  rq;
        logic [3:0]  ls;
        rq = '0;

        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1);
        probe();
        chk("reset_busy", int'(busy), 0);
        chk("reset_we",   int'(fifo_we), 0);

        // Single requester: bubble, then A1/A2/A3 on consecutive cycles.
        cyc(4'b0001, lane(0, 8'hA1), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0001, lane(0, 8'hA1), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0001, lane(0, 8'hA2), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0001, lane(0, 8'hA3), 4'b0001, 1'b0, 1'b0);
        probe();
        chk("single_last_data", int'(fifo_wd), 8'hA3);
        cyc(4'b0011, 32'h0, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0011, 32'h0, 4'b0011, 1'b0, 1'b0);
        probe();
        chk("single_ptr_next", int'(owner), 1);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0);

        // Fairness from a fresh reset: five bursts of four, one bubble each.
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b1);
        snap = n_we;
        wr_owner.delete();
        for (int c = 0; c < 25; c++) cyc(4'b1111, $urandom, 4'b0000, 1'b0, 1'b0);
        probe();
        chk("fair_writes", n_we - snap, 20);
        chk("fair_count_q", wr_owner.size(), 20);
        if (wr_owner.size() == 20) begin
            chk("fair_b0", wr_owner[0], 0);
            chk("fair_b1", wr_owner[4], 1);
            chk("fair_b2", wr_owner[8], 2);
            chk("fair_b3", wr_owner[12], 3);
            chk("fair_b4", wr_owner[16], 0);
        end
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0);

        // Back-pressure on a requester 2 burst.
        cyc(4'b0100, lane(2, 8'hB1), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0100, lane(2, 8'hB1), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0100, lane(2, 8'hB2), 4'b0000, 1'b1, 1'b0);
        cyc(4'b0100, lane(2, 8'hB2), 4'b0000, 1'b1, 1'b0);
        probe();
        chk("bp_no_we", int'(fifo_we), 0);
        chk("bp_cnt_hold", int'(beat_cnt), 1);
        cyc(4'b0100, lane(2, 8'hB2), 4'b0100, 1'b1, 1'b0);
        cyc(4'b0100, lane(2, 8'hB2), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0100, lane(2, 8'hB3), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0100, lane(2, 8'hB4), 4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0);

        // Withdrawal by owner 1 after two beats.
        cyc(4'b0010, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0010, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0010, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b1000, $urandom, 4'b0000, 1'b0, 1'b0);
        probe();
        chk("wd_cnt_reached", int'(beat_cnt), 2);
        chk("wd_no_we", int'(fifo_we), 0);
        cyc(4'b1000, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b1000, $urandom, 4'b1000, 1'b0, 1'b0);
        probe();
        chk("wd_next_owner", int'(owner), 3);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0);

        // Reset asserted while beat_cnt is 2.
        cyc(4'b0100, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0100, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0100, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0100, $urandom, 4'b0000, 1'b0, 1'b1);
        probe();
        chk("rst_mid_gnt",  int'(gnt), 0);
        chk("rst_mid_we",   int'(fifo_we), 0);
        chk("rst_mid_busy", int'(busy), 0);
        cyc(4'b0101, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0101, $urandom, 4'b0001, 1'b0, 1'b0);
        probe();
        chk("rst_after_owner", int'(owner), 0);

        // Wrap: owner 2 finishes, pointer 3, req 0011 must go to 0.
        cyc(4'b0100, $urandom, 4'b0100, 1'b0, 1'b0);
        cyc(4'b0100, $urandom, 4'b0100, 1'b0, 1'b0);
        cyc(4'b0011, $urandom, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0011, $urandom, 4'b0001, 1'b0, 1'b0);
        probe();
        chk("wrap_owner", int'(owner), 0);

        // Randomized traffic with sticky requests, back-pressure and rare resets.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            ls = 4'($urandom) & 4'($urandom);
            cyc(rq, $urandom, ls, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
        end

        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0);
        cyc(4'b0000, 32'h0, 4'b0000, 1'b0, 1'b0);
        probe();
        chk("wq_drained", wq.size(), 0);
        chk("sq_drained", sq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 Parameters (name, default, meaning) SHALL be:
- N, 4, number of requesters (>=2).
- DW, 8, data width.
- MAXBURST, 4, maximum beats per grant (>=1).
- IW, $clog2(N), owner index width.
- CW, $clog2(MAXBURST+1), beat-counter width.

REQ-002 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, single clock, all state on rising edge.
- reset, in, 1, asynchronous, active-high reset.
- req, in, N, requester i has a beat to write.
- data, in, N*DW, requester i data at bits [i*DW +: DW].
- last, in, N, requester i current beat ends its burst.
- gnt, out, N, beat of requester i accepted this cycle.
- fifo_we, out, 1, write strobe to the downstream FIFO.
- fifo_wd, out, DW, write data to the downstream FIFO.
- fifo_full, in, 1, downstream FIFO full.
- busy, out, 1, a burst is locked.
- owner, out, IW, index of the locked requester.
- beat_cnt, out, CW, beats accepted in the current burst.

Function
REQ-003 The FSM SHALL have exactly two states: IDLE and BURST.

REQ-004 In IDLE with req!=0, the block SHALL pick the first set req bit searching upward from prio_ptr, wrapping N-1 to 0. It SHALL register that index into owner, clear beat_cnt, and enter BURST on the next edge.

REQ-005 In IDLE, gnt, fifo_we and busy SHALL all be 0; arbitration costs exactly one bubble cycle.

REQ-006 In BURST, a beat SHALL be accepted when req[owner] & ~fifo_full. On acceptance:
- gnt[owner]=1 and fifo_we=1 combinationally in the same cycle.
- fifo_wd=data[owner]; beat_cnt increments at the edge.

REQ-007 gnt SHALL be one-hot or zero, and gnt[i]=1 only for i==owner.

REQ-008 When fifo_full=1, no beat SHALL be accepted; the block SHALL hold BURST with owner and beat_cnt unchanged.

REQ-009 BURST SHALL return to IDLE at the edge following:
- an accepted beat with last[owner]=1, or
- an accepted beat that brings beat_cnt to MAXBURST.

REQ-010 BURST SHALL return to IDLE with no write when req[owner]=0 (requester withdrew).

REQ-011 On every BURST->IDLE transition, prio_ptr SHALL become owner+1 modulo N.

REQ-012 prio_ptr SHALL be unchanged while in IDLE.

REQ-013 Requests from non-owners during BURST SHALL be ignored, with no gnt and no state change.

REQ-014 busy SHALL be 1 exactly in BURST.

REQ-015 owner and beat_cnt outputs SHALL be the registered values.

REQ-016 fifo_wd SHALL equal data[owner] whenever busy=1, and 0 in IDLE.

REQ-017 beat_cnt SHALL never exceed MAXBURST and SHALL saturate by the transition rule, never by wrap.

REQ-018 fifo_full rising in the same cycle as a last beat SHALL block that beat; the burst ends only when the last beat is actually accepted.

Reset
REQ-019 reset=1 SHALL asynchronously force:
- state=IDLE
- prio_ptr=0, owner=0, beat_cnt=0
- gnt=0, fifo_we=0, busy=0, fifo_wd=0

REQ-020 Reset asserted mid-burst SHALL drop gnt and fifo_we in the same cycle, with no partial write.

REQ-021 After reset deasserts, the first arbitration SHALL search from index 0.

Structure
REQ-022 A shared package fifo_arb_pkg SHALL hold the state enum type (IDLE, BURST) and default parameter constants.

REQ-023 A sub-module rr_pick SHALL implement the combinational round-robin search. Its inputs are req[N] and prio_ptr; its outputs are valid and the winner index.

REQ-024 The block SHALL contain no FIFO storage and SHALL connect only to a FIFO's write port.

Verification
REQ-025 The bench SHALL cover these directed scenarios (defaults N=4, DW=8, MAXBURST=4):
- Single requester: req=0001, 3 beats 0xA1/0xA2/0xA3, last on beat 3 -> IDLE one cycle, then gnt[0] on 3 consecutive cycles, writes A1, A2, A3, prio_ptr=1.
- Fairness: req=1111 held, each requester streaming with last=0 -> grants in order 0,1,2,3,0, each 4 beats; one IDLE bubble between bursts; 20 writes in 25 cycles.
- Back-pressure: fifo_full=1 for cycles 2-4 of a requester 2 burst -> no fifo_we during those cycles; beat_cnt holds at 1; the burst completes after full clears, with data order preserved.
- Withdrawal: owner 1 drops req after 2 beats -> next cycle IDLE, beat_cnt had reached 2, prio_ptr=2, requester 3 wins if req=1000.
- Reset mid-burst: reset asserted while beat_cnt=2 -> gnt=0, fifo_we=0, busy=0 in the same cycle; after release, req=0101 gives the grant to 0.
- Wrap: prio_ptr=3, req=0011 -> owner=0, not 1.
